// File: rtl/mult_accum.sv
// Windowed signed accumulator for 2x2 multiplier products.
// Sums N_TERMS products with saturation, then holds the result for a handshake.
module mult_accum #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       y,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sat
);

    typedef enum logic {ACC, HOLD} state_t;

    localparam logic [7:0] LAST = 8'(N_TERMS - 1);

    state_t           r_state;
    logic [ACC_W-1:0] r_sum;
    logic [7:0]       r_cnt;
    logic             r_flag;
    logic [ACC_W-1:0] r_acc_out;
    logic             r_sat;

    logic [ACC_W:0]   w_ext;
    logic [ACC_W:0]   w_full;
    logic             w_ovf;
    logic [ACC_W-1:0] w_sum;
    logic             w_flag;

    // One guard bit catches overflow; its sign picks the clamp direction.
    always_comb begin
        w_ext  = {{(ACC_W - 3){y[3]}}, y};
        w_full = {r_sum[ACC_W-1], r_sum} + w_ext;
        w_ovf  = w_full[ACC_W] ^ w_full[ACC_W-1];
        w_sum  = w_full[ACC_W-1:0];
        if (w_ovf) begin
            w_sum = w_full[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                  : {1'b0, {(ACC_W - 1){1'b1}}};
        end
        w_flag = r_flag | w_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ACC;
            r_sum     <= '0;
            r_cnt     <= '0;
            r_flag    <= 1'b0;
            r_acc_out <= '0;
            r_sat     <= 1'b0;
        end else begin
            unique case (r_state)
                ACC: begin
                    if (in_valid) begin
                        if (r_cnt == LAST) begin
                            r_acc_out <= w_sum;
                            r_sat     <= w_flag;
                            r_state   <= HOLD;
                        end else begin
                            r_sum  <= w_sum;
                            r_cnt  <= r_cnt + 8'd1;
                            r_flag <= w_flag;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_flag  <= 1'b0;
                        r_state <= ACC;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ACC);
    assign out_valid = (r_state == HOLD);
    assign acc_out   = r_acc_out;
    assign sat       = r_sat;

endmodule

// File: tb/tb_mult_accum.sv
// Directed bench for mult_accum: ACC_W=8 and ACC_W=5 instances share stimulus.
module tb_mult_accum;

    logic       clk;
    logic       rst_n;
    logic [3:0] y;
    logic       in_valid;
    logic       out_ready;

    logic       rdy8, ov8, sat8;
    logic [7:0] acc8;
    logic       rdy5, ov5, sat5;
    logic [4:0] acc5;

    int n_checks = 0;
    int n_fail   = 0;

    mult_accum #(.N_TERMS(4), .ACC_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .y(y), .in_valid(in_valid),
        .in_ready(rdy8), .acc_out(acc8), .out_valid(ov8),
        .out_ready(out_ready), .sat(sat8)
    );

    mult_accum #(.N_TERMS(4), .ACC_W(5)) u5 (
        .clk(clk), .rst_n(rst_n), .y(y), .in_valid(in_valid),
        .in_ready(rdy5), .acc_out(acc5), .out_valid(ov5),
        .out_ready(out_ready), .sat(sat5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept four products and land in HOLD, checking both result sets.
    task automatic fill(input int a, input int b, input int c, input int d,
                        input logic [7:0] e8, input logic e8s,
                        input logic [4:0] e5, input logic e5s);
        int v[4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("in_ready_acc", 32'(rdy8), 32'd1);
            check("out_valid_acc", 32'(ov8), 32'd0);
            y         = 4'(v[i]);
            in_valid  = 1'b1;
            out_ready = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("out_valid_8", 32'(ov8), 32'd1);
        check("in_ready_hold", 32'(rdy8), 32'd0);
        check("acc_out_8", 32'(acc8), 32'(e8));
        check("sat_8", 32'(sat8), 32'(e8s));
        check("acc_out_5", 32'(acc5), 32'(e5));
        check("sat_5", 32'(sat5), 32'(e5s));
    endtask

    task automatic release_hold();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_clr", 32'(ov8), 32'd0);
        check("in_ready_back", 32'(rdy8), 32'd1);
        check("out_valid_clr5", 32'(ov5), 32'd0);
    endtask

    initial begin
        int pat[7];
        pat       = '{1, 0, 0, 1, 1, 0, 1};
        rst_n     = 1'b0;
        y         = 4'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_acc_out", 32'(acc8), 32'd0);
        check("rst_sat", 32'(sat8), 32'd0);
        check("rst_out_valid", 32'(ov8), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(rdy8), 32'd1);

        fill(3, 3, 3, 3, 8'h0C, 1'b0, 5'h0C, 1'b0);
        release_hold();
        fill(-6, -6, -6, -6, 8'hE8, 1'b0, 5'h10, 1'b1);
        release_hold();
        fill(1, -2, 3, 0, 8'h02, 1'b0, 5'h02, 1'b0);
        release_hold();
        fill(1, 1, 1, 1, 8'h04, 1'b0, 5'h04, 1'b0);
        release_hold();

        // Back-pressure: HOLD must ignore valid products.
        fill(3, 3, 3, 3, 8'h0C, 1'b0, 5'h0C, 1'b0);
        for (int i = 0; i < 5; i++) begin
            y        = (i % 2 == 0) ? 4'd3 : 4'hA;
            in_valid = 1'b1;
            @(negedge clk);
            check("hold_acc", 32'(acc8), 32'h0C);
            check("hold_sat", 32'(sat8), 32'd0);
            check("hold_in_ready", 32'(rdy8), 32'd0);
            check("hold_out_valid", 32'(ov8), 32'd1);
        end
        in_valid = 1'b0;
        release_hold();
        check("retain_acc", 32'(acc8), 32'h0C);
        fill(1, 1, 1, 1, 8'h04, 1'b0, 5'h04, 1'b0);
        release_hold();

        for (int i = 0; i < 7; i++) begin
            check("gap_no_result", 32'(ov8), 32'd0);
            in_valid = pat[i][0];
            y        = pat[i] != 0 ? 4'd2 : 4'd3;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("gap_out_valid", 32'(ov8), 32'd1);
        check("gap_acc", 32'(acc8), 32'h08);
        check("gap_acc5", 32'(acc5), 32'h08);
        release_hold();

        // Asynchronous reset mid-window.
        y        = 4'd3;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_acc", 32'(acc8), 32'd0);
        check("arst_sat", 32'(sat8), 32'd0);
        check("arst_out_valid", 32'(ov8), 32'd0);
        #1 rst_n = 1'b1;
        fill(1, 1, 1, 1, 8'h04, 1'b0, 5'h04, 1'b0);

        // Asynchronous reset while holding a result.
        #2 rst_n = 1'b0;
        #1;
        check("hrst_out_valid", 32'(ov8), 32'd0);
        check("hrst_acc", 32'(acc8), 32'd0);
        #1 rst_n = 1'b1;
        fill(2, 2, -1, 0, 8'h03, 1'b0, 5'h03, 1'b0);
        release_hold();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_accum.md
MULT_ACCUM -- requirements
Module: mult_accum

Parameters
REQ-001 The block SHALL have parameter N_TERMS, default 4, giving the number of products summed per output window; legal range 1..255.
REQ-002 The block SHALL have parameter ACC_W, default 8, giving the signed accumulator and result width; legal range 5..16.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port y, input, 4 bits: the product from the upstream 2x2 multiplier, interpreted as signed two's complement (legal range -6..+3).
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream product on y is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a product this cycle.
REQ-008 The block SHALL have port acc_out, output, ACC_W bits: the signed window sum.
REQ-009 The block SHALL have port out_valid, output, 1 bit: acc_out and sat are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes the result.
REQ-011 The block SHALL have port sat, output, 1 bit: saturation occurred in the reported window.

Function
REQ-012 The FSM SHALL have two states, ACC and HOLD; in_ready=1 exactly in ACC and out_valid=1 exactly in HOLD, both decoded from registered state only.
REQ-013 A product SHALL be accepted when in_valid & in_ready; y is sign-extended to ACC_W and added to the running sum.
REQ-014 Each addition SHALL saturate to the signed range [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any clamp sets a sticky window saturation flag.
REQ-015 A term counter SHALL increment per accepted product; cycles with in_valid=0 leave sum, counter and flag unchanged.
REQ-016 On the cycle the N_TERMS-th product is accepted, the block SHALL register the saturated final sum into acc_out and the flag into sat, and move to HOLD; out_valid rises the next cycle (latency 1 from the last accept).
REQ-017 In HOLD, acc_out and sat SHALL be held stable and y/in_valid ignored until out_ready=1.
REQ-018 On the out_ready=1 cycle in HOLD, the block SHALL clear the running sum, counter and sticky flag, and return to ACC; in_ready rises the next cycle (no same-cycle bypass); minimum period N_TERMS+1 cycles per window.
REQ-019 With N_TERMS=1, every accepted product SHALL produce its own result window.
REQ-020 acc_out SHALL retain the last result after leaving HOLD until the next window completes; only out_valid qualifies it.

Reset
REQ-021 While rst_n=0, the state SHALL be ACC; sum, counter, flag, acc_out and sat SHALL be 0; and out_valid SHALL be 0; in_ready SHALL be 1 from the first clock edge after rst_n deasserts.
REQ-022 Reset asserted mid-window or in HOLD SHALL discard partial sums and any pending result; the following window starts from zero.

Verification (N_TERMS=4, ACC_W=8 unless stated)
REQ-023 The bench SHALL cover: y=3,3,3,3 with in_valid continuous -> out_valid one cycle after the 4th accept, acc_out=0x0C, sat=0.
REQ-024 The bench SHALL cover: y=-6 x4 -> acc_out=0xE8 (-24), sat=0; then y=1,-2,3,0 -> acc_out=0x02.
REQ-025 The bench SHALL cover: ACC_W=5, y=-6 x4 -> acc_out=0x10 (-16), sat=1; next window y=1 x4 -> acc_out=0x04, sat=0 (flag cleared).
REQ-026 The bench SHALL cover: out_ready held 0 for 5 cycles in HOLD while in_valid=1, y toggling -> acc_out/sat stable, in_ready=0, no term counted; out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
REQ-027 The bench SHALL cover: in_valid gaps (pattern 1,0,0,1,1,0,1) with y=2 on valid cycles -> single result 0x08 after the 4th valid.
REQ-028 The bench SHALL cover: accept y=3,3, then pulse rst_n low asynchronously mid-cycle -> outputs zero immediately; then y=1 x4 -> acc_out=0x04.
